// File: rtl/eprisc_bus_master_pkg.sv
// Shared epRISC byte-bus definitions: FSM encodings, frame geometry, request word layout
// and the peripheral-reset address the controller recognises.
package eprisc_bus_master_pkg;

  localparam logic [1:0] sResync = 2'd0;
  localparam logic [1:0] sIdle   = 2'd1;
  localparam logic [1:0] sLow    = 2'd2;
  localparam logic [1:0] sHigh   = 2'd3;

  localparam int BEAT_COUNT      = 6;
  localparam int MOSI_LAST_BEAT  = 4;
  localparam int MISO_FIRST_BEAT = 2;
  localparam int MISO_LAST_BEAT  = 5;

  localparam logic [14:0] RESET_ADDR = 15'h7FFF;

  typedef struct packed {
    logic        write;
    logic [14:0] addr;
    logic [15:0] data;
  } busWord_t;

  // Lane 0 is the least significant byte; the bus carries lanes in ascending order.
  function automatic logic [7:0] getLane(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] laneByte;
    case (lane)
      2'd0:    laneByte = word[7:0];
      2'd1:    laneByte = word[15:8];
      2'd2:    laneByte = word[23:16];
      default: laneByte = word[31:24];
    endcase
    return laneByte;
  endfunction

endpackage

// File: rtl/eprisc_bus_clkgen.sv
// Bus-clock phase generator: counts CLK_DIV system cycles per bus half period and
// flags the cycle on which the bus clock should rise or fall.
module eprisc_bus_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic iClk,
  input  logic iRst,
  input  logic run,
  output logic riseTick,
  output logic fallTick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] phaseCnt;
  logic          phaseHigh;
  logic          terminal;

  assign terminal = run && (phaseCnt == CW'(CLK_DIV - 1));
  assign riseTick = terminal && !phaseHigh;
  assign fallTick = terminal && phaseHigh;

  // Held cleared while idle so every frame starts with a full low half period.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      phaseCnt  <= '0;
      phaseHigh <= 1'b0;
    end else if (!run) begin
      phaseCnt  <= '0;
      phaseHigh <= 1'b0;
    end else if (terminal) begin
      phaseCnt  <= '0;
      phaseHigh <= !phaseHigh;
    end else begin
      phaseCnt <= phaseCnt + CW'(1);
    end
  end

endmodule

// File: rtl/eprisc_bus_master.sv
// epRISC byte-bus master: turns single 32-bit requests into 6-beat bus frames and returns
// the captured MISO word. Build option BUSMASTER_AUTOFLUSH_EN doubles read frames.
module eprisc_bus_master
  import eprisc_bus_master_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int RESYNC_CYCLES = 8
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic        iReqWrite,
  input  logic [14:0] iReqAddr,
  input  logic [15:0] iReqData,
  input  logic [1:0]  iReqSel,
  output logic        oRspValid,
  output logic [31:0] oRspData,
  output logic [14:0] oRspAddr,
  output logic        oBusClock,
  output logic [1:0]  oBusSelect,
  output logic [7:0]  oBusMOSI,
  input  logic [7:0]  iBusMISO,
  input  logic        iBusInterrupt,
  output logic        oIrq
);

  localparam int RW = $clog2(RESYNC_CYCLES + 1);

  logic          wInternalReset;
  logic [1:0]    state;
  busWord_t      word;
  logic [2:0]    beat;
  logic [RW-1:0] resyncCnt;
  logic [14:0]   lastAddr;
  logic          rspPending;
  logic          busRun;
  logic          riseTick;
  logic          fallTick;
  logic          irqMeta;
  logic [1:0]    mosiLane;
  logic [1:0]    misoLane;
`ifdef BUSMASTER_AUTOFLUSH_EN
  logic          flushPending;
  logic          flushSecond;
`endif

  assign wInternalReset = iRst;
  assign busRun   = (state == sLow) || (state == sHigh);
  assign mosiLane = 2'(beat - 3'd1);
  assign misoLane = 2'(beat - 3'd2);

`ifdef BUSMASTER_AUTOFLUSH_EN
  assign oReqReady = (state == sIdle) && !flushPending;
`else
  assign oReqReady = (state == sIdle);
`endif

  eprisc_bus_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) clkGen (
    .iClk     (iClk),
    .iRst     (wInternalReset),
    .run      (busRun),
    .riseTick (riseTick),
    .fallTick (fallTick)
  );

  // Frame sequencer. Bus outputs change only on tick cycles, so a rising edge, its MOSI
  // byte and the MISO capture for that beat are all registered on the same iClk edge.
  always_ff @(posedge iClk or posedge wInternalReset) begin
    if (wInternalReset) begin
      state      <= sResync;
      resyncCnt  <= '0;
      word       <= '0;
      beat       <= '0;
      lastAddr   <= '0;
      rspPending <= 1'b0;
      oRspValid  <= 1'b0;
      oRspData   <= '0;
      oRspAddr   <= '0;
      oBusClock  <= 1'b0;
      oBusSelect <= 2'h0;
      oBusMOSI   <= '0;
`ifdef BUSMASTER_AUTOFLUSH_EN
      flushPending <= 1'b0;
      flushSecond  <= 1'b0;
`endif
    end else begin
      oRspValid  <= rspPending;
      rspPending <= 1'b0;
      case (state)
        sResync: begin
          oBusSelect <= 2'h0;
          lastAddr   <= '0;
          if (resyncCnt == RW'(RESYNC_CYCLES - 1)) begin
            state <= sIdle;
          end else begin
            resyncCnt <= resyncCnt + RW'(1);
          end
        end
        sIdle: begin
`ifdef BUSMASTER_AUTOFLUSH_EN
          if (flushPending) begin
            flushPending <= 1'b0;
            flushSecond  <= 1'b1;
            beat         <= 3'd1;
            state        <= sLow;
          end else
`endif
          if (iReqValid) begin
            if (iReqSel == 2'h0) begin
              oBusSelect <= 2'h0;
              resyncCnt  <= '0;
              state      <= sResync;
            end else begin
              word       <= {iReqWrite, iReqAddr, iReqData};
              oBusSelect <= iReqSel;
              beat       <= 3'd1;
              state      <= sLow;
            end
          end
        end
        sLow: begin
          if (riseTick) begin
            oBusClock <= 1'b1;
            state     <= sHigh;
            if (int'(beat) <= MOSI_LAST_BEAT) begin
              oBusMOSI <= getLane(word, mosiLane);
            end
            if (int'(beat) >= MISO_FIRST_BEAT && int'(beat) <= MISO_LAST_BEAT) begin
              case (misoLane)
                2'd0:    oRspData[7:0]   <= iBusMISO;
                2'd1:    oRspData[15:8]  <= iBusMISO;
                2'd2:    oRspData[23:16] <= iBusMISO;
                default: oRspData[31:24] <= iBusMISO;
              endcase
            end
          end
        end
        default: begin
          if (fallTick) begin
            oBusClock <= 1'b0;
            if (int'(beat) == BEAT_COUNT) begin
              state    <= sIdle;
              lastAddr <= word.addr;
`ifdef BUSMASTER_AUTOFLUSH_EN
              // The repeat frame reads back the address the first frame just latched.
              if (!word.write && !flushSecond) begin
                flushPending <= 1'b1;
              end
              if (!word.write && flushSecond) begin
                rspPending <= 1'b1;
                oRspAddr   <= lastAddr;
              end
              flushSecond <= 1'b0;
`else
              rspPending <= 1'b1;
              oRspAddr   <= lastAddr;
`endif
            end else begin
              beat  <= beat + 3'd1;
              state <= sLow;
            end
          end
        end
      endcase
    end
  end

  // Two-flop synchronizer for the controller's asynchronous interrupt line.
  always_ff @(posedge iClk or posedge wInternalReset) begin
    if (wInternalReset) begin
      irqMeta <= 1'b0;
      oIrq    <= 1'b0;
    end else begin
      irqMeta <= iBusInterrupt;
      oIrq    <= irqMeta;
    end
  end

endmodule

// File: tb/tb_eprisc_bus_master.sv
// Bench for eprisc_bus_master: pin-level controller model on the bus, word-level reference
// memory for expected responses, scoreboard queue drained by an independent monitor.
module tb_eprisc_bus_master;
  import eprisc_bus_master_pkg::*;

  localparam int CLK_DIV       = 2;
  localparam int RESYNC_CYCLES = 8;
`ifdef BUSMASTER_AUTOFLUSH_EN
  localparam int LAT = 24 * CLK_DIV + 2;
`else
  localparam int LAT = 12 * CLK_DIV + 1;
`endif

  typedef struct {
    logic [14:0] addr;
    logic [31:0] data;
    int          cycle;
  } expRsp_t;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iReqValid;
  logic        oReqReady;
  logic        iReqWrite;
  logic [14:0] iReqAddr;
  logic [15:0] iReqData;
  logic [1:0]  iReqSel;
  logic        oRspValid;
  logic [31:0] oRspData;
  logic [14:0] oRspAddr;
  logic        oBusClock;
  logic [1:0]  oBusSelect;
  logic [7:0]  oBusMOSI;
  logic [7:0]  iBusMISO;
  logic        iBusInterrupt;
  logic        oIrq;

  int assertCount = 0;
  int failCount   = 0;
  int cycleCount  = 0;
  int busEdges    = 0;

  expRsp_t     expQ[$];
  expRsp_t     monExp;
  logic [31:0] refMem [0:32767];
  logic [14:0] refPrevAddr;
  logic [31:0] preload [0:7];

  // Controller model state: 0=Load 1=LoLo 2=Lo 3=Hi 4=HiHi 5=Store
  logic [31:0] ctlMem [0:32767];
  int          ctlState = 0;
  logic [31:0] ctlShift = '0;
  logic [14:0] ctlAddr = '0;
  logic [31:0] ctlLastWord = '0;
  logic        prevBusClock = 1'b0;
  logic        memLoaded = 1'b0;

  eprisc_bus_master #(
    .CLK_DIV       (CLK_DIV),
    .RESYNC_CYCLES (RESYNC_CYCLES)
  ) dut (
    .iClk          (iClk),
    .iRst          (iRst),
    .iReqValid     (iReqValid),
    .oReqReady     (oReqReady),
    .iReqWrite     (iReqWrite),
    .iReqAddr      (iReqAddr),
    .iReqData      (iReqData),
    .iReqSel       (iReqSel),
    .oRspValid     (oRspValid),
    .oRspData      (oRspData),
    .oRspAddr      (oRspAddr),
    .oBusClock     (oBusClock),
    .oBusSelect    (oBusSelect),
    .oBusMOSI      (oBusMOSI),
    .iBusMISO      (iBusMISO),
    .iBusInterrupt (iBusInterrupt),
    .oIrq          (oIrq)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) cycleCount <= cycleCount + 1;
  always @(posedge oBusClock) busEdges <= busEdges + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Controller model, evaluated half a cycle after each system edge when bus pins are stable.
  always @(negedge iClk) begin
    if (!memLoaded) begin
      for (int i = 0; i < 32768; i++) ctlMem[i] = 32'h0;
      for (int k = 0; k < 8; k++) ctlMem[32'h40 + k] = preload[k];
      memLoaded = 1'b1;
    end
    if (oBusSelect == 2'h0) begin
      ctlState     = 0;
      ctlAddr      = '0;
      prevBusClock = oBusClock;
    end else begin
      if (oBusClock && !prevBusClock) begin
        if (ctlState == 5) begin
          ctlState = 0;
          ctlAddr  = ctlShift[30:16];
        end else begin
          ctlState = ctlState + 1;
          if (ctlState == 5) begin
            ctlLastWord = ctlShift;
            if (ctlShift[31]) ctlMem[ctlShift[30:16]] = {16'h0, ctlShift[15:0]};
          end
        end
      end else if (!oBusClock && prevBusClock) begin
        case (ctlState)
          1: ctlShift[7:0]   = oBusMOSI;
          2: ctlShift[15:8]  = oBusMOSI;
          3: ctlShift[23:16] = oBusMOSI;
          4: ctlShift[31:24] = oBusMOSI;
          default: ;
        endcase
      end
      prevBusClock = oBusClock;
    end
  end

  always_comb begin
    iBusMISO = 8'h00;
    case (ctlState)
      1: iBusMISO = ctlMem[ctlAddr][7:0];
      2: iBusMISO = ctlMem[ctlAddr][15:8];
      3: iBusMISO = ctlMem[ctlAddr][23:16];
      4: iBusMISO = ctlMem[ctlAddr][31:24];
      default: ;
    endcase
  end

  // Monitor: every response strobe must match the oldest outstanding expectation.
  always @(negedge iClk) begin
    if (oRspValid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("rspUnexpected", 32'(oRspAddr), 32'hFFFF_FFFF);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("rspData", oRspData, monExp.data);
        checkOutput("rspAddr", 32'(oRspAddr), 32'(monExp.addr));
        checkOutput("rspCycle", 32'(cycleCount), 32'(monExp.cycle));
      end
    end
  end

  task automatic waitReady(output int cycles);
    cycles = 0;
    while (oReqReady !== 1'b1 && cycles < 1000) begin
      @(posedge iClk);
      #1;
      cycles++;
    end
    if (cycles >= 1000) checkOutput("readyTimeout", 32'(cycles), 32'd0);
  endtask

  task automatic applyStimulus(input logic w, input logic [14:0] a, input logic [15:0] d,
                               input logic [1:0] s, input logic waitDone);
    int      n;
    int      acceptCycle;
    int      edgesBefore;
    int      expEdges;
    expRsp_t item;
    waitReady(n);
    iReqWrite = w;
    iReqAddr  = a;
    iReqData  = d;
    iReqSel   = s;
    iReqValid = 1'b1;
    edgesBefore = busEdges;
    @(posedge iClk);
    #1;
    acceptCycle = cycleCount;
    iReqValid = 1'b0;
    checkOutput("busSelect", 32'(oBusSelect), 32'(s));
    expEdges = 6;
    if (s == 2'h0) begin
      refPrevAddr = '0;
    end else begin
      item.cycle = acceptCycle + LAT;
`ifdef BUSMASTER_AUTOFLUSH_EN
      if (!w) begin
        item.addr = a;
        item.data = refMem[a];
        expQ.push_back(item);
        expEdges = 12;
      end
`else
      item.addr = refPrevAddr;
      item.data = refMem[refPrevAddr];
      expQ.push_back(item);
`endif
      if (w) refMem[a] = {16'h0, d};
      refPrevAddr = a;
    end
    if (waitDone) begin
      waitReady(n);
      if (s == 2'h0) begin
        checkOutput("resyncLen", 32'(n), 32'(RESYNC_CYCLES));
        checkOutput("resyncEdges", 32'(busEdges - edgesBefore), 32'd0);
      end else begin
        checkOutput("frameEdges", 32'(busEdges - edgesBefore), 32'(expEdges));
        checkOutput("mosiWord", ctlLastWord, {w, a, d});
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int guard;
    logic        rw;
    logic [14:0] ra;
    logic [1:0]  rs;

    iRst = 1'b1;
    iReqValid = 1'b0;
    iReqWrite = 1'b0;
    iReqAddr = '0;
    iReqData = '0;
    iReqSel = 2'h0;
    iBusInterrupt = 1'b0;
    preload[0] = 32'hDEAD_BEEF;
    for (int k = 1; k < 8; k++) preload[k] = $urandom;
    for (int i = 0; i < 32768; i++) refMem[i] = 32'h0;
    for (int k = 0; k < 8; k++) refMem[32'h40 + k] = preload[k];
    refPrevAddr = '0;

    #2;
    checkOutput("rstSelect", 32'(oBusSelect), 32'd0);
    checkOutput("rstBusClock", 32'(oBusClock), 32'd0);
    checkOutput("rstMosi", 32'(oBusMOSI), 32'd0);
    checkOutput("rstReady", 32'(oReqReady), 32'd0);
    checkOutput("rstRspValid", 32'(oRspValid), 32'd0);
    checkOutput("rstRspData", oRspData, 32'd0);
    checkOutput("rstRspAddr", 32'(oRspAddr), 32'd0);
    checkOutput("rstIrq", 32'(oIrq), 32'd0);

    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    waitReady(n);
    checkOutput("startupResyncLen", 32'(n), 32'(RESYNC_CYCLES));
    checkOutput("startupEdges", 32'(busEdges), 32'd0);
    checkOutput("idleBusClock", 32'(oBusClock), 32'd0);

    @(negedge iClk);
    iBusInterrupt = 1'b1;
    @(posedge iClk);
    #1;
    checkOutput("irqStage1", 32'(oIrq), 32'd0);
    @(posedge iClk);
    #1;
    checkOutput("irqStage2", 32'(oIrq), 32'd1);
    iBusInterrupt = 1'b0;

    applyStimulus(1'b1, 15'h0012, 16'hBEEF, 2'h1, 1'b1);
    applyStimulus(1'b0, 15'h0040, 16'h0000, 2'h1, 1'b1);
    applyStimulus(1'b0, 15'h0041, 16'h0000, 2'h1, 1'b1);
    applyStimulus(1'b0, 15'h0042, 16'h5555, 2'h2, 1'b1);
    applyStimulus(1'b1, RESET_ADDR, 16'hA5A5, 2'h3, 1'b1);
    applyStimulus(1'b0, 15'h0043, 16'h0000, 2'h0, 1'b1);
    applyStimulus(1'b0, 15'h0040, 16'h0000, 2'h1, 1'b1);

    // Abort a frame mid-flight with an asynchronous reset.
    applyStimulus(1'b0, 15'h0044, 16'h0000, 2'h1, 1'b0);
    guard = 0;
    while (ctlState != 3 && guard < 200) begin
      @(negedge iClk);
      guard++;
    end
    checkOutput("reachBeat3", 32'(ctlState), 32'd3);
    #2;
    iRst = 1'b1;
    #1;
    checkOutput("abortBusClock", 32'(oBusClock), 32'd0);
    checkOutput("abortSelect", 32'(oBusSelect), 32'd0);
    expQ.delete();
    refPrevAddr = '0;
    @(negedge iClk);
    iRst = 1'b0;
    waitReady(n);
    checkOutput("abortResyncLen", 32'(n), 32'(RESYNC_CYCLES));
    applyStimulus(1'b1, 15'h0041, 16'h1234, 2'h1, 1'b1);
    checkOutput("modelWrite41", ctlMem[15'h0041], 32'h0000_1234);
    applyStimulus(1'b0, 15'h0041, 16'h0000, 2'h2, 1'b1);

    for (int t = 0; t < 40; t++) begin
      rw = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 9) == 0) ? RESET_ADDR : 15'(32'h40 + $urandom_range(0, 7));
      rs = ($urandom_range(0, 9) == 0) ? 2'h0 : 2'($urandom_range(1, 3));
      applyStimulus(rw, ra, 16'($urandom), rs, 1'b1);
    end

    repeat (4 * LAT) @(negedge iClk);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
